// File: rtl/mmio_interconnect_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_if : CPU data port, slave channels and error status of the MMIO bus   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mmio_if #(
  parameter int NSLAVES = 4
);
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_rstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_rbusy;
  logic                  mem_wbusy;
  logic [NSLAVES-1:0]    s_rd;
  logic [NSLAVES-1:0]    s_wr;
  logic [32*NSLAVES-1:0] s_rdata;
  logic [NSLAVES-1:0]    s_rbusy;
  logic [NSLAVES-1:0]    s_wbusy;
  logic                  err_clr;
  logic                  bus_err;
  logic [1:0]            err_code;
  logic [31:0]           err_addr;

  // Environment side: CPU plus the peripherals behind the interconnect.
  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_rbusy, s_wbusy, err_clr,
    input  mem_rdata, mem_rbusy, mem_wbusy, s_rd, s_wr, bus_err, err_code, err_addr
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_rbusy, s_wbusy, err_clr,
    output mem_rdata, mem_rbusy, mem_wbusy, s_rd, s_wr, bus_err, err_code, err_addr
  );
endinterface
`default_nettype wire

// File: rtl/mmio_interconnect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_interconnect : page decoder, one-outstanding-access tracker, timeout   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mmio_interconnect #(
  parameter int                    NSLAVES       = 4,
  parameter logic [16*NSLAVES-1:0] BASES         = {16'h0041, 16'h0040, 16'h0001, 16'h0000},
  parameter int                    DEFAULT_SLAVE = NSLAVES,
  parameter int                    TIMEOUT       = 255
) (
  input  logic  clk,
  input  logic  resetn,
  mmio_if.slave bus
);
  localparam int              SW       = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int              CW       = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0]   TO_VAL   = CW'(TIMEOUT);
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam bit              DEF_OK   = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NSLAVES);
  localparam logic [SW-1:0]   DEF_IDX  = SW'(DEF_OK ? DEFAULT_SLAVE : 0);
  localparam logic [1:0]      ERR_UNMAP = 2'b01;
  localparam logic [1:0]      ERR_TMO   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t        state_q;
  logic [SW-1:0] cur_q;
  logic          abort_q;
  logic          abort_to_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          bus_err_q;
  logic [1:0]    err_code_q;
  logic [31:0]   err_addr_q;

  logic          hit;
  logic [SW-1:0] sel;
  logic          wr_req;
  logic          rd_req;
  logic          idle;
  logic          busy_cur;
  logic          to_hit;
  logic          log_err;
  logic [1:0]    log_code;
  logic [31:0]   log_addr;
  logic          w_unused_wdata;

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if (bus.mem_addr[31:16] == BASES[16*k +: 16]) begin
        hit = 1'b1;
        sel = SW'(k);
      end
    end
    if (!hit && DEF_OK) begin
      hit = 1'b1;
      sel = DEF_IDX;
    end
  end

  assign wr_req   = |bus.mem_wmask;
  assign rd_req   = bus.mem_rstrb & ~wr_req;
  assign idle     = (state_q == S_IDLE);
  assign busy_cur = (state_q == S_WR) ? bus.s_wbusy[cur_q] : bus.s_rbusy[cur_q];
  assign to_hit   = TO_EN && !idle && busy_cur && (cnt_q == TO_VAL);

  assign bus.s_rd      = (idle && rd_req && hit) ? (NSLAVES'(1) << sel) : '0;
  assign bus.s_wr      = (idle && wr_req && hit) ? (NSLAVES'(1) << sel) : '0;
  assign bus.mem_rbusy = (state_q == S_RD) && bus.s_rbusy[cur_q] && !to_hit;
  assign bus.mem_wbusy = (state_q == S_WR) && bus.s_wbusy[cur_q] && !to_hit;
  // Data follows the latched slot so it survives the CPU moving mem_addr on.
  assign bus.mem_rdata = abort_q ? {32{abort_to_q}} : bus.s_rdata[32*cur_q +: 32];
  assign bus.bus_err   = bus_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_addr  = err_addr_q;

  always_comb begin
    log_err  = 1'b0;
    log_code = 2'b00;
    log_addr = 32'h0;
    if (idle && (wr_req || rd_req) && !hit) begin
      log_err  = 1'b1;
      log_code = ERR_UNMAP;
      log_addr = bus.mem_addr;
    end else if (to_hit) begin
      log_err  = 1'b1;
      log_code = ERR_TMO;
      log_addr = addr_q;
    end
  end

  assign w_unused_wdata = ^bus.mem_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      abort_q    <= 1'b0;
      abort_to_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      bus_err_q  <= 1'b0;
      err_code_q <= 2'b00;
      err_addr_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_req) begin
            if (hit) begin
              cur_q   <= sel;
              addr_q  <= bus.mem_addr;
              cnt_q   <= '0;
              state_q <= S_WR;
            end
          end else if (rd_req) begin
            if (hit) begin
              cur_q   <= sel;
              addr_q  <= bus.mem_addr;
              cnt_q   <= '0;
              abort_q <= 1'b0;
              state_q <= S_RD;
            end else begin
              abort_q    <= 1'b1;
              abort_to_q <= 1'b0;
            end
          end
        end
        S_RD, S_WR: begin
          if (!busy_cur) begin
            state_q <= S_IDLE;
          end else if (to_hit) begin
            state_q    <= S_IDLE;
            abort_q    <= 1'b1;
            abort_to_q <= 1'b1;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (log_err) begin
        bus_err_q  <= 1'b1;
        err_code_q <= log_code;
        err_addr_q <= log_addr;
      end else if (bus.err_clr) begin
        bus_err_q  <= 1'b0;
        err_code_q <= 2'b00;
        err_addr_q <= 32'h0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mmio_interconnect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmio_interconnect : two differently configured interconnects, one model |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mmio_interconnect;
  logic         clk;
  logic         resetn;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [3:0]   wmask;
  logic         rstrb;
  logic         err_clr;
  logic [127:0] srdata;
  logic [3:0]   srbusy;
  logic [3:0]   swbusy;
  int           vectors;
  int           miscompares;
  int           nb;

  mmio_if #(.NSLAVES(4)) ifa ();
  mmio_if #(.NSLAVES(4)) ifb ();

  // A: slot 3 duplicates slot 0, no default slot, short timeout.
  mmio_interconnect #(
    .NSLAVES(4), .BASES(64'h0000_0040_0001_0000), .DEFAULT_SLAVE(4), .TIMEOUT(5)
  ) dut_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));

  // B: stock page table, unmapped goes to slot 0, timeout disabled.
  mmio_interconnect #(
    .NSLAVES(4), .BASES(64'h0041_0040_0001_0000), .DEFAULT_SLAVE(0), .TIMEOUT(0)
  ) dut_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));

  assign ifa.mem_addr  = addr;    assign ifb.mem_addr  = addr;
  assign ifa.mem_wdata = wdata;   assign ifb.mem_wdata = wdata;
  assign ifa.mem_wmask = wmask;   assign ifb.mem_wmask = wmask;
  assign ifa.mem_rstrb = rstrb;   assign ifb.mem_rstrb = rstrb;
  assign ifa.s_rdata   = srdata;  assign ifb.s_rdata   = srdata;
  assign ifa.s_rbusy   = srbusy;  assign ifb.s_rbusy   = srbusy;
  assign ifa.s_wbusy   = swbusy;  assign ifb.s_wbusy   = swbusy;
  assign ifa.err_clr   = err_clr; assign ifb.err_clr   = err_clr;

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%08h, want 0x%08h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_base [2][4] = '{'{16'h0000, 16'h0001, 16'h0040, 16'h0000},
                                 '{16'h0000, 16'h0001, 16'h0040, 16'h0041}};
  int          m_def  [2] = '{4, 0};
  int          m_tmo  [2] = '{5, 0};
  int          m_pend [2];   // slot with an access in flight, -1 when none
  bit          m_pwr  [2];
  int          m_wait [2];   // cycles the in-flight slave has reported busy
  int          m_dsrc [2];   // slot feeding mem_rdata; -1 zero, -2 all ones
  logic [31:0] m_taddr[2];
  bit          m_err  [2];
  logic [1:0]  m_code [2];
  logic [31:0] m_eaddr[2];

  function automatic int decode(input int i, input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (a[31:16] == m_base[i][k]) return k;
    if (m_def[i] < 4) return m_def[i];
    return -1;
  endfunction

  always @(negedge clk) begin
    int          sel;
    bit          idle, wr, rd, busy, expire;
    logic [3:0]  e_srd, e_swr;
    logic [31:0] e_rdata;
    logic [31:0] g_rdata, g_eaddr;
    logic [3:0]  g_srd, g_swr;
    logic        g_rbusy, g_wbusy, g_err;
    logic [1:0]  g_code;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        m_pend[i] = -1; m_pwr[i] = 0; m_wait[i] = 0; m_dsrc[i] = 0; m_taddr[i] = 0;
        m_err[i] = 0; m_code[i] = 0; m_eaddr[i] = 0;
      end
      if (i == 0) begin
        g_rdata = ifa.mem_rdata; g_rbusy = ifa.mem_rbusy; g_wbusy = ifa.mem_wbusy;
        g_srd = ifa.s_rd; g_swr = ifa.s_wr; g_err = ifa.bus_err;
        g_code = ifa.err_code; g_eaddr = ifa.err_addr;
      end else begin
        g_rdata = ifb.mem_rdata; g_rbusy = ifb.mem_rbusy; g_wbusy = ifb.mem_wbusy;
        g_srd = ifb.s_rd; g_swr = ifb.s_wr; g_err = ifb.bus_err;
        g_code = ifb.err_code; g_eaddr = ifb.err_addr;
      end
      idle   = (m_pend[i] < 0);
      sel    = decode(i, addr);
      wr     = |wmask;
      rd     = rstrb && !wr;
      busy   = !idle && (m_pwr[i] ? swbusy[m_pend[i]] : srbusy[m_pend[i]]);
      expire = busy && (m_tmo[i] != 0) && (m_wait[i] == m_tmo[i]);
      e_srd  = (idle && rd && sel >= 0) ? 4'(1 << sel) : 4'b0;
      e_swr  = (idle && wr && sel >= 0) ? 4'(1 << sel) : 4'b0;
      if (m_dsrc[i] >= 0)       e_rdata = srdata[32*m_dsrc[i] +: 32];
      else if (m_dsrc[i] == -1) e_rdata = 32'h0;
      else                      e_rdata = 32'hFFFF_FFFF;

      cmp("rdata",    i, g_rdata, e_rdata);
      cmp("rbusy",    i, 32'(g_rbusy), 32'(busy && !m_pwr[i] && !expire));
      cmp("wbusy",    i, 32'(g_wbusy), 32'(busy && m_pwr[i] && !expire));
      cmp("s_rd",     i, 32'(g_srd), 32'(e_srd));
      cmp("s_wr",     i, 32'(g_swr), 32'(e_swr));
      cmp("bus_err",  i, 32'(g_err), 32'(m_err[i]));
      cmp("err_code", i, 32'(g_code), 32'(m_code[i]));
      cmp("err_addr", i, g_eaddr, m_eaddr[i]);

      if (resetn) begin
        if (idle && (wr || rd) && sel < 0) begin
          m_err[i] = 1; m_code[i] = 2'b01; m_eaddr[i] = addr;
        end else if (expire) begin
          m_err[i] = 1; m_code[i] = 2'b10; m_eaddr[i] = m_taddr[i];
        end else if (err_clr) begin
          m_err[i] = 0; m_code[i] = 0; m_eaddr[i] = 0;
        end
        if (idle) begin
          if (wr && sel >= 0) begin
            m_pend[i] = sel; m_pwr[i] = 1; m_wait[i] = 0; m_taddr[i] = addr;
            if (m_dsrc[i] >= 0) m_dsrc[i] = sel;
          end else if (rd && sel >= 0) begin
            m_pend[i] = sel; m_pwr[i] = 0; m_wait[i] = 0; m_taddr[i] = addr; m_dsrc[i] = sel;
          end else if (rd) begin
            m_dsrc[i] = -1;
          end
        end else if (!busy) begin
          m_pend[i] = -1;
        end else if (expire) begin
          m_pend[i] = -1; m_dsrc[i] = -2;
        end else begin
          m_wait[i]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clk = 0; resetn = 0; addr = 0; wdata = 0; wmask = 0; rstrb = 0; err_clr = 0;
    srbusy = 0; swbusy = 0;
    srdata = {32'h3333_3333, 32'h0000_0041, 32'h1111_1111, 32'hA0A0_0000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_rdata", 0, ifa.mem_rdata, 32'hA0A0_0000);
    cmp("rst_rbusy", 0, 32'(ifa.mem_rbusy), 0);
    cmp("rst_err",   0, 32'(ifa.bus_err), 0);
    step();
    resetn = 1;

    // Read slot 2, slave busy three cycles after the strobe.
    addr = 32'h0040_0004; rstrb = 1;
    @(negedge clk);
    cmp("rd_strobe", 0, 32'(ifa.s_rd), 32'h4);
    cmp("rd_strobe", 1, 32'(ifb.s_rd), 32'h4);
    step();
    rstrb = 0; srbusy[2] = 1; nb = 0;
    repeat (3) begin @(negedge clk); nb += int'(ifa.mem_rbusy); step(); end
    srbusy[2] = 0;
    @(negedge clk);
    nb += int'(ifa.mem_rbusy);
    cmp("rd_busy_cycles", 0, 32'(nb), 3);
    step();
    @(negedge clk);
    cmp("rd_data",  0, ifa.mem_rdata, 32'h0000_0041);
    cmp("rd_noerr", 0, 32'(ifa.bus_err), 0);
    step();

    // Write slot 1; address moves away while the slave is busy.
    addr = 32'h0001_0008; wmask = 4'b0001; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cmp("wr_strobe", 0, 32'(ifa.s_wr), 32'h2);
    cmp("wr_strobe", 1, 32'(ifb.s_wr), 32'h2);
    step();
    wmask = 0; swbusy[1] = 1; addr = 32'h0;
    @(negedge clk);
    cmp("wr_busy", 0, 32'(ifa.mem_wbusy), 1);
    step(); step();
    swbusy[1] = 0;
    @(negedge clk);
    cmp("wr_done", 0, 32'(ifa.mem_wbusy), 0);
    step();

    // Unmapped read: error on A, default slot 0 on B.
    addr = 32'h0050_0000; rstrb = 1;
    @(negedge clk);
    cmp("unm_srd", 0, 32'(ifa.s_rd), 0);
    cmp("unm_srd", 1, 32'(ifb.s_rd), 32'h1);
    step();
    rstrb = 0;
    @(negedge clk);
    cmp("unm_rdata", 0, ifa.mem_rdata, 32'h0);
    cmp("unm_err",   0, 32'(ifa.bus_err), 1);
    cmp("unm_code",  0, 32'(ifa.err_code), 32'h1);
    cmp("unm_addr",  0, ifa.err_addr, 32'h0050_0000);
    cmp("def_err",   1, 32'(ifb.bus_err), 0);
    cmp("def_rdata", 1, ifb.mem_rdata, 32'hA0A0_0000);
    step();

    // Slot 1 stuck busy: A times out after 5 stall cycles, B waits forever.
    addr = 32'h0001_0000; srbusy[1] = 1; rstrb = 1;
    step();
    rstrb = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nb += int'(ifa.mem_rbusy);
      step();
      rstrb = (i == 1);
    end
    rstrb = 0;
    @(negedge clk);
    cmp("to_busy_cycles", 0, 32'(nb), 5);
    cmp("to_rdata", 0, ifa.mem_rdata, 32'hFFFF_FFFF);
    cmp("to_code",  0, 32'(ifa.err_code), 32'h2);
    cmp("to_addr",  0, ifa.err_addr, 32'h0001_0000);
    cmp("no_to_rbusy", 1, 32'(ifb.mem_rbusy), 1);
    cmp("no_to_err",   1, 32'(ifb.bus_err), 0);
    step();
    err_clr = 1;
    step();
    err_clr = 0;
    @(negedge clk);
    cmp("clr_err",  0, 32'(ifa.bus_err), 0);
    cmp("clr_code", 0, 32'(ifa.err_code), 0);
    cmp("clr_addr", 0, ifa.err_addr, 32'h0);
    srbusy[1] = 0;
    step(); step();

    // Duplicate page: slot 0 wins over slot 3; write beats a same-cycle read.
    addr = 32'h0000_0010; rstrb = 1;
    @(negedge clk);
    cmp("dup_srd", 0, 32'(ifa.s_rd), 32'h1);
    step();
    rstrb = 0;
    step();
    addr = 32'h0; wmask = 4'b1111; rstrb = 1;
    @(negedge clk);
    cmp("both_swr", 0, 32'(ifa.s_wr), 32'h1);
    cmp("both_srd", 0, 32'(ifa.s_rd), 32'h0);
    step();
    wmask = 0; rstrb = 0;
    step();

    // Unmapped write.
    addr = 32'h0050_0000; wmask = 4'b0011;
    @(negedge clk);
    cmp("uwr_swr", 0, 32'(ifa.s_wr), 0);
    cmp("uwr_swr", 1, 32'(ifb.s_wr), 32'h1);
    step();
    wmask = 0;
    @(negedge clk);
    cmp("uwr_code", 0, 32'(ifa.err_code), 32'h1);
    step();

    // Reset in the middle of a stalled read.
    addr = 32'h0001_0000; srbusy[1] = 1; rstrb = 1;
    step();
    rstrb = 0;
    step(); step();
    cmp("pre_rst_rbusy", 0, 32'(ifa.mem_rbusy), 1);
    #2 resetn = 0;
    #1;
    cmp("arst_rbusy", 0, 32'(ifa.mem_rbusy), 0);
    cmp("arst_rbusy", 1, 32'(ifb.mem_rbusy), 0);
    cmp("arst_err",   0, 32'(ifa.bus_err), 0);
    cmp("arst_code",  0, 32'(ifa.err_code), 0);
    cmp("arst_addr",  0, ifa.err_addr, 32'h0);
    @(negedge clk);
    step();
    srbusy = 0; resetn = 1;
    step(); step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
